// File: rtl/xor_parity_sequencer.sv
// xor_parity_sequencer
// Shares one bit-serial XOR stage among N_REQ requesters. A requester is
// granted, its word is latched, then shifted LSB-first through the XOR stage
// into an accumulator. The result is reported with a one-cycle done pulse
// together with the requester index.
//
// Build option: define XOR_SEQ_RR_EN for round-robin arbitration. Without it
// the arbiter is fixed priority (lowest index wins) and no pointer exists.
module xor_parity_sequencer #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     parity
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Registered state
  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic              acc;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   win_id;

  // Next-state values
  state_t            state_d;
  logic [WIDTH-1:0]  shreg_d;
  logic              acc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [ID_W-1:0]   win_id_d;
  logic [N_REQ-1:0]  gnt_d;
  logic              busy_d;
  logic              done_d;
  logic [ID_W-1:0]   done_id_d;
  logic              parity_d;

  // Arbiter result
  logic              arb_found;
  logic [ID_W-1:0]   arb_id;

`ifdef XOR_SEQ_RR_EN
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_d;

  // Round-robin search: scan from the pointer, wrapping; the first high
  // request wins. Scanning downward lets the nearest index overwrite others.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end
`else
  // Fixed priority: the lowest-index high request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(k);
      end
    end
  end
`endif

  // Next-state and next-output logic for the grant/shift/report sequence.
  always_comb begin
    // NOTE: every value gets a hold default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state;
    shreg_d   = shreg;
    acc_d     = acc;
    cnt_d     = cnt;
    win_id_d  = win_id;
    gnt_d     = gnt;
    busy_d    = busy;
    done_d    = 1'b0;
    done_id_d = done_id;
    parity_d  = parity;
`ifdef XOR_SEQ_RR_EN
    rr_ptr_d  = rr_ptr;
`endif

    unique case (state)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << arb_id;
          busy_d   = 1'b1;
          win_id_d = arb_id;
          shreg_d  = data[int'(arb_id)*WIDTH +: WIDTH];
          acc_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        acc_d   = acc ^ shreg[0];
        shreg_d = shreg >> 1;
        cnt_d   = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          parity_d  = acc ^ shreg[0];
          done_id_d = win_id;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef XOR_SEQ_RR_EN
        if (win_id == ID_W'(N_REQ - 1)) rr_ptr_d = '0;
        else                            rr_ptr_d = win_id + 1'b1;
`endif
      end

      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is a small datapath register, not a memory,
    // so it is reset along with the rest to give a defined restart.
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      acc     <= 1'b0;
      cnt     <= '0;
      win_id  <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      parity  <= 1'b0;
`ifdef XOR_SEQ_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, regardless of statement order.
      state   <= state_d;
      shreg   <= shreg_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      win_id  <= win_id_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
      done    <= done_d;
      done_id <= done_id_d;
      parity  <= parity_d;
`ifdef XOR_SEQ_RR_EN
      rr_ptr  <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_xor_parity_sequencer.sv
// Scoreboard bench for xor_parity_sequencer: the stimulus process pushes the
// expected (id, parity) per operation; a monitor pops on every done pulse.
module tb_xor_parity_sequencer;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = $clog2(N_REQ);

  logic                     clk;
  logic                     rst_n;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   data;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic                     parity;

  xor_parity_sequencer #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .parity  (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic par;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               mdl_ptr = 0;
  logic [WIDTH-1:0] words [N_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ*WIDTH-1:0] pack_words();
    logic [N_REQ*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) v[i*WIDTH +: WIDTH] = words[i];
    return v;
  endfunction

  // Reference arbiter: first high request starting from the pointer
  // (round-robin) or from index 0 (fixed priority).
  function automatic int model_winner(input logic [N_REQ-1:0] pat);
    for (int k = 0; k < N_REQ; k++) begin
`ifdef XOR_SEQ_RR_EN
      if (pat[(mdl_ptr + k) % N_REQ]) return (mdl_ptr + k) % N_REQ;
`else
      if (pat[k]) return k;
`endif
    end
    return -1;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_id=%0d with no pending operation", done_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", 32'(done_id), 32'(e.id));
        check("parity", 32'(parity), 32'(e.par));
      end
    end
  end

  // Called at a negedge: pulse reset, verify outputs clear, release.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_parity", 32'(parity), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_ptr = 0;
  endtask

  // One operation, started at a negedge with the DUT idle.
  // scramble: 0 none, 1 all-ones, 2 random words during SHIFT.
  task automatic run_op(input logic [N_REQ-1:0] pat, input int scramble,
                        input int drop_bit, input int drop_at, input int abort_at);
    int   w;
    exp_t e;
    req  = pat;
    data = pack_words();
    w    = model_winner(pat);
    e.id  = w;
    e.par = ($countones(words[w]) % 2) == 1;
    sb.push_back(e);
`ifdef XOR_SEQ_RR_EN
    mdl_ptr = (w + 1) % N_REQ;
`endif
    @(posedge clk);
    @(negedge clk);
    check("grant_onehot", 32'(gnt), 32'(1) << w);
    check("busy_set", 32'(busy), 1);
    for (int c = 1; c <= WIDTH; c++) begin
      if (abort_at == c - 1) begin
        void'(sb.pop_back());
        apply_reset();
        return;
      end
      if (drop_at == c - 1) req[drop_bit] = 1'b0;
      if (scramble == 1) for (int i = 0; i < N_REQ; i++) words[i] = '1;
      if (scramble == 2) for (int i = 0; i < N_REQ; i++) words[i] = WIDTH'($urandom);
      data = pack_words();
      @(posedge clk);
      @(negedge clk);
      if (c == WIDTH / 2) check("gnt_stable", 32'(gnt), 32'(1) << w);
    end
    check("done_pulse", 32'(done), 1);
    @(posedge clk);
    @(negedge clk);
    check("done_cleared", 32'(done), 0);
    check("gnt_cleared", 32'(gnt), 0);
    check("busy_cleared", 32'(busy), 0);
    check("parity_held", 32'(parity), 32'(e.par));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N_REQ; i++) words[i] = '0;
    data  = pack_words();
    repeat (2) @(negedge clk);
    check("init_gnt", 32'(gnt), 0);
    check("init_busy", 32'(busy), 0);
    check("init_done", 32'(done), 0);
    check("init_parity", 32'(parity), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 0xA5 has even weight
    for (int i = 0; i < N_REQ; i++) words[i] = WIDTH'($urandom);
    words[0] = 8'hA5;
    run_op(4'b0001, 0, 0, -1, -1);

    // Word changes during SHIFT must not affect the latched 0x07
    words[1] = 8'h07;
    run_op(4'b0010, 1, 0, -1, -1);

    // Edge-bit words on requester 2, back to back
    words[2] = 8'h80; run_op(4'b0100, 0, 0, -1, -1);
    words[2] = 8'h01; run_op(4'b0100, 0, 0, -1, -1);
    words[2] = 8'h00; run_op(4'b0100, 0, 0, -1, -1);
    words[2] = 8'hFF; run_op(4'b0100, 0, 0, -1, -1);

    // All requesters held for five operations from a fresh pointer
    apply_reset();
    for (int i = 0; i < N_REQ; i++) words[i] = WIDTH'($urandom);
    for (int n = 0; n < 5; n++) run_op(4'b1111, 0, 0, -1, -1);

    // Reset at E4: no done for the aborted word, then re-grant completes
    words[2] = 8'h3B;
    run_op(4'b0100, 0, 0, -1, 4);
    run_op(4'b0100, 0, 0, -1, -1);

    // Requester 0 drops at E2; operation still completes, then 1 is served
    apply_reset();
    words[0] = 8'h13;
    words[1] = 8'hC1;
    run_op(4'b0011, 0, 0, 2, -1);
    run_op(4'b0010, 0, 0, -1, -1);

    // Random patterns and words
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N_REQ; i++) words[i] = WIDTH'($urandom);
      run_op(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), int'($urandom_range(0, 2)), 0, -1, -1);
    end

    req = '0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
